id_stage: RTL

- Consumer end of the IF/ID interface: takes the buffered 16-bit instruction and its 8-bit address from the IF/ID buffer.
- Decodes the instruction and reads a 16x16 register file.
- Detects load-use hazards and registers decoded fields into the ID/EX pipeline register for the execute stage.
- Returns stall back to the PC and IF/ID buffer; accepts flush and writeback from later stages.

---
 rtl/id_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ------------------------------------------------------------------------
// id_stage - decode, 16x16 register file, load-use stall, ID/EX register. Rev 1.0
// ------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREG   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              instruc_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     valid_in,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [3:0]               ex_opcode,
  output logic [$clog2(NREG)-1:0]  ex_rd,
  output logic [DATA_W-1:0]        ex_a,
  output logic [DATA_W-1:0]        ex_b,
  output logic [DATA_W-1:0]        ex_imm,
  output logic [ADDR_W-1:0]        ex_addr,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic                     ex_jump,
  output logic                     illegal
);

  localparam int RW = $clog2(NREG);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_ILLO = 4'hA;
  localparam logic [3:0] OP_ILHI = 4'hE;

  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        op;
  logic [RW-1:0]     rd_i, rs_i, rt_i;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val;
  logic [DATA_W-1:0] imm;
  logic              reads_rs, reads_rt, reads_rd;
  logic              dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_ill;

  assign op   = instruc_in[15:12];
  assign rd_i = instruc_in[11:8];
  assign rs_i = instruc_in[7:4];
  assign rt_i = instruc_in[3:0];

  // R0 is hardwired to zero; a same-cycle writeback is forwarded to the read.
  assign rs_val = (rs_i == '0) ? '0 : (wb_en && wb_rd == rs_i) ? wb_data : regs[rs_i];
  assign rt_val = (rt_i == '0) ? '0 : (wb_en && wb_rd == rt_i) ? wb_data : regs[rt_i];
  assign rd_val = (rd_i == '0) ? '0 : (wb_en && wb_rd == rd_i) ? wb_data : regs[rd_i];

  assign imm = (op == OP_JMP) ? {{(DATA_W-8){1'b0}}, instruc_in[7:0]}
                              : {{(DATA_W-4){instruc_in[3]}}, instruc_in[3:0]};

  always_comb begin
    dec_rw   = (op >= OP_ADD) && (op <= OP_LW);
    dec_mr   = (op == OP_LW);
    dec_mw   = (op == OP_SW);
    dec_br   = (op == OP_BEQ);
    dec_jp   = (op == OP_JMP);
    dec_ill  = (op >= OP_ILLO) && (op <= OP_ILHI);
    reads_rs = (op >= OP_ADD) && (op <= OP_BEQ);
    reads_rt = (op >= OP_ADD) && (op <= OP_OR);
    reads_rd = (op == OP_SW) || (op == OP_BEQ);
  end

  always_comb begin
    stall = 1'b0;
    if (valid_in && !flush && ex_valid && ex_mem_read && ex_rd != '0)
      stall = (reads_rs && ex_rd == rs_i) ||
              (reads_rt && ex_rd == rt_i) ||
              (reads_rd && ex_rd == rd_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_rd        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_imm       <= '0;
      ex_addr      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      ex_valid     <= valid_in;
      ex_opcode    <= op;
      ex_rd        <= rd_i;
      ex_a         <= rs_val;
      // SW stores R[rd]; BEQ compares R[rd] against R[rs], so both carry R[rd] in B.
      ex_b         <= (op == OP_SW || op == OP_BEQ) ? rd_val : rt_val;
      ex_imm       <= imm;
      ex_addr      <= addr_in;
      ex_reg_write <= valid_in && dec_rw;
      ex_mem_read  <= valid_in && dec_mr;
      ex_mem_write <= valid_in && dec_mw;
      ex_branch    <= valid_in && dec_br;
      ex_jump      <= valid_in && dec_jp;
      illegal      <= valid_in && dec_ill;
    end
  end

endmodule
`default_nettype wire
